// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cook timer.
package microwave_pkg;

  typedef enum logic [1:0] {T_SETUP, T_RUN, T_DONE} timer_state_t;

  typedef struct packed {
    logic [3:0] min;
    logic [3:0] s10;
    logic [3:0] s1;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = '0;

  // One-second BCD decrement; callers only use it on a non-zero time.
  function automatic bcd_time_t bcd_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.s1 != 4'd0) begin
      r.s1 = t.s1 - 4'd1;
    end else begin
      r.s1 = 4'd9;
      if (t.s10 != 4'd0) begin
        r.s10 = t.s10 - 4'd1;
      end else begin
        r.s10 = 4'd5;
        r.min = t.min - 4'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mw_prescaler.sv
// Seconds prescaler: counts enabled cycles and flags the last cycle of each second.
module mw_prescaler #(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICKS_PER_SEC);
  localparam logic [W-1:0] LAST = W'(TICKS_PER_SEC - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Cook-time entry and countdown feeding the microwave control FSM.
//
// state   | meaning
// T_SETUP | keys edit the BCD time, start key launches a cook
// T_RUN   | time counts down while the FSM drives heat
// T_DONE  | finish held until the FSM has rung the bell and the door opens
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       door,
  input  logic       key_min,
  input  logic       key_sec10,
  input  logic       key_start,
  input  logic       key_clear,
  input  logic       heat,
  input  logic       bell,
  output logic       start,
  output logic       finish,
  output logic [3:0] disp_min,
  output logic [3:0] disp_s10,
  output logic [3:0] disp_s1,
  output logic       running
);

  timer_state_t state;
  bcd_time_t    tm;
  bcd_time_t    tm_dec;
  logic         seen_bell;
  logic [3:0]   key_q;
  logic [3:0]   keys;
  logic [3:0]   key_edge;
  logic         start_go;
  logic         tick;

  assign keys     = {key_start, key_clear, key_min, key_sec10};
  assign key_edge = keys & ~key_q;
  assign tm_dec   = bcd_dec(tm);
  assign start_go = (state == T_SETUP) && key_edge[3] && (tm != TIME_ZERO) && !door;

  assign disp_min = tm.min;
  assign disp_s10 = tm.s10;
  assign disp_s1  = tm.s1;

  mw_prescaler #(.TICKS_PER_SEC(TICKS_PER_SEC)) u_prescaler (
    .clk  (clk),
    .nrst (nrst),
    .en   (heat & running),
    .clr  (start_go),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= T_SETUP;
      tm        <= TIME_ZERO;
      seen_bell <= 1'b0;
      key_q     <= '0;
      start     <= 1'b0;
      finish    <= 1'b0;
      running   <= 1'b0;
    end else begin
      key_q <= keys;
      start <= 1'b0;
      case (state)
        T_SETUP: begin
          // A start edge swallows every other key that cycle, even when refused.
          if (key_edge[3]) begin
            if (start_go) begin
              state   <= T_RUN;
              running <= 1'b1;
              start   <= 1'b1;
            end
          end else if (key_edge[2]) begin
            tm <= TIME_ZERO;
          end else if (key_edge[1]) begin
            tm.min <= (tm.min == 4'd9) ? 4'd0 : tm.min + 4'd1;
          end else if (key_edge[0]) begin
            tm.s10 <= (tm.s10 == 4'd5) ? 4'd0 : tm.s10 + 4'd1;
          end
        end
        T_RUN: begin
          if (key_edge[2]) begin
            tm      <= TIME_ZERO;
            state   <= T_DONE;
            running <= 1'b0;
            finish  <= 1'b1;
          end else if (tick) begin
            tm <= tm_dec;
            if (tm_dec == TIME_ZERO) begin
              state   <= T_DONE;
              running <= 1'b0;
              finish  <= 1'b1;
            end
          end
        end
        T_DONE: begin
          // Door opening before the bell is a pause; only BELL->OPEN releases.
          if (seen_bell && door) begin
            state     <= T_SETUP;
            finish    <= 1'b0;
            seen_bell <= 1'b0;
          end else if (bell) begin
            seen_bell <= 1'b1;
          end
        end
        default: begin
          state   <= T_SETUP;
          running <= 1'b0;
          finish  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with a 4-cycle second.
module tb_microwave_timer;

  logic       clk = 1'b0;
  logic       nrst;
  logic       door, key_min, key_sec10, key_start, key_clear, heat, bell;
  logic       start, finish, running;
  logic [3:0] disp_min, disp_s10, disp_s1;
  logic [14:0] obs;
  int vec = 0;
  int errs = 0;

  microwave_timer #(.TICKS_PER_SEC(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .door      (door),
    .key_min   (key_min),
    .key_sec10 (key_sec10),
    .key_start (key_start),
    .key_clear (key_clear),
    .heat      (heat),
    .bell      (bell),
    .start     (start),
    .finish    (finish),
    .disp_min  (disp_min),
    .disp_s10  (disp_s10),
    .disp_s1   (disp_s1),
    .running   (running)
  );

  always #5 clk = ~clk;

  // {start, finish, running, M, S10, S1}
  assign obs = {start, finish, running, disp_min, disp_s10, disp_s1};

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // k: 0=min 1=sec10 2=start 3=clear
  task automatic press(input int k);
    case (k)
      0: key_min = 1'b1;
      1: key_sec10 = 1'b1;
      2: key_start = 1'b1;
      default: key_clear = 1'b1;
    endcase
    step(1);
    key_min = 1'b0; key_sec10 = 1'b0; key_start = 1'b0; key_clear = 1'b0;
    step(1);
  endtask

  task automatic test_reset;
    nrst = 1'b0;
    door = 0; key_min = 0; key_sec10 = 0; key_start = 0; key_clear = 0; heat = 0; bell = 0;
    step(2);
    vec++; if (obs !== 15'h0) begin errs++; $display("FAIL reset_hold: got %h exp %h", obs, 15'h0); end
    nrst = 1'b1;
    step(1);
    vec++; if (obs !== 15'h0) begin errs++; $display("FAIL reset_release: got %h exp %h", obs, 15'h0); end
  endtask

  task automatic test_entry;
    press(0); press(0);
    vec++; if (obs !== {3'b000, 12'h200}) begin errs++; $display("FAIL min_x2: got %h exp %h", obs, {3'b000, 12'h200}); end
    for (int i = 0; i < 5; i++) press(1);
    vec++; if (obs !== {3'b000, 12'h250}) begin errs++; $display("FAIL sec10_x5: got %h exp %h", obs, {3'b000, 12'h250}); end
    press(1); press(1);
    vec++; if (obs !== {3'b000, 12'h210}) begin errs++; $display("FAIL sec10_wrap: got %h exp %h", obs, {3'b000, 12'h210}); end
    key_min = 1'b1; step(5); key_min = 1'b0; step(1);
    vec++; if (obs !== {3'b000, 12'h310}) begin errs++; $display("FAIL min_hold: got %h exp %h", obs, {3'b000, 12'h310}); end
    for (int i = 0; i < 7; i++) press(0);
    vec++; if (obs !== {3'b000, 12'h010}) begin errs++; $display("FAIL min_wrap: got %h exp %h", obs, {3'b000, 12'h010}); end
    key_clear = 1'b1; key_min = 1'b1; step(1); key_clear = 1'b0; key_min = 1'b0; step(1);
    vec++; if (obs !== {3'b000, 12'h000}) begin errs++; $display("FAIL clear_over_min: got %h exp %h", obs, {3'b000, 12'h000}); end
  endtask

  task automatic test_countdown;
    press(0);
    key_start = 1'b1; step(1);
    vec++; if (obs !== {3'b101, 12'h100}) begin errs++; $display("FAIL start_pulse: got %h exp %h", obs, {3'b101, 12'h100}); end
    key_start = 1'b0; step(1);
    vec++; if (obs !== {3'b001, 12'h100}) begin errs++; $display("FAIL start_one_cycle: got %h exp %h", obs, {3'b001, 12'h100}); end
    heat = 1'b1; step(3);
    vec++; if (obs !== {3'b001, 12'h100}) begin errs++; $display("FAIL pre_tick: got %h exp %h", obs, {3'b001, 12'h100}); end
    step(1);
    vec++; if (obs !== {3'b001, 12'h059}) begin errs++; $display("FAIL borrow: got %h exp %h", obs, {3'b001, 12'h059}); end
    heat = 1'b0; step(10);
    vec++; if (obs !== {3'b001, 12'h059}) begin errs++; $display("FAIL heat_pause: got %h exp %h", obs, {3'b001, 12'h059}); end
    press(0); press(1);
    vec++; if (obs !== {3'b001, 12'h059}) begin errs++; $display("FAIL run_keys_ignored: got %h exp %h", obs, {3'b001, 12'h059}); end
    key_clear = 1'b1; step(1); key_clear = 1'b0;
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL run_clear: got %h exp %h", obs, {3'b010, 12'h000}); end
    bell = 1'b1; step(1); bell = 1'b0; door = 1'b1; step(1);
    vec++; if (obs !== {3'b000, 12'h000}) begin errs++; $display("FAIL clear_exit: got %h exp %h", obs, {3'b000, 12'h000}); end
    door = 1'b0; step(1);
  endtask

  task automatic test_finish;
    press(1);
    key_start = 1'b1; step(1); key_start = 1'b0;
    heat = 1'b1; step(36);
    vec++; if (obs !== {3'b001, 12'h001}) begin errs++; $display("FAIL at_0_01: got %h exp %h", obs, {3'b001, 12'h001}); end
    step(3);
    vec++; if (obs !== {3'b001, 12'h001}) begin errs++; $display("FAIL last_sec_hold: got %h exp %h", obs, {3'b001, 12'h001}); end
    step(1);
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL finish: got %h exp %h", obs, {3'b010, 12'h000}); end
    heat = 1'b0; step(3);
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL no_dec_done: got %h exp %h", obs, {3'b010, 12'h000}); end
    bell = 1'b1; step(1); bell = 1'b0; step(1);
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL bell_wait_door: got %h exp %h", obs, {3'b010, 12'h000}); end
    door = 1'b1; step(1);
    vec++; if (obs !== {3'b000, 12'h000}) begin errs++; $display("FAIL bell_door_exit: got %h exp %h", obs, {3'b000, 12'h000}); end
    door = 1'b0; step(1);
  endtask

  task automatic test_door_before_bell;
    press(1);
    press(2);
    press(3);
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL enter_done: got %h exp %h", obs, {3'b010, 12'h000}); end
    door = 1'b1; step(3);
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL door_no_bell: got %h exp %h", obs, {3'b010, 12'h000}); end
    press(1);
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL done_keys_ignored: got %h exp %h", obs, {3'b010, 12'h000}); end
    door = 1'b0; step(1);
    bell = 1'b1; step(1); bell = 1'b0; door = 1'b1; step(1);
    vec++; if (obs !== {3'b000, 12'h000}) begin errs++; $display("FAIL pause_then_exit: got %h exp %h", obs, {3'b000, 12'h000}); end
    door = 1'b0; step(1);
  endtask

  task automatic test_start_ignored;
    key_start = 1'b1; step(1);
    vec++; if (obs !== {3'b000, 12'h000}) begin errs++; $display("FAIL start_at_zero: got %h exp %h", obs, {3'b000, 12'h000}); end
    key_start = 1'b0; step(1);
    for (int i = 0; i < 4; i++) press(1);
    door = 1'b1;
    key_start = 1'b1; step(1);
    vec++; if (obs !== {3'b000, 12'h040}) begin errs++; $display("FAIL start_door_open: got %h exp %h", obs, {3'b000, 12'h040}); end
    key_start = 1'b0; door = 1'b0; step(1);
    press(1);
    key_start = 1'b1; step(1); key_start = 1'b0;
    heat = 1'b1; step(20);
    vec++; if (obs !== {3'b001, 12'h045}) begin errs++; $display("FAIL at_0_45: got %h exp %h", obs, {3'b001, 12'h045}); end
    step(3);
    key_clear = 1'b1; step(1); key_clear = 1'b0; heat = 1'b0;
    vec++; if (obs !== {3'b010, 12'h000}) begin errs++; $display("FAIL clear_vs_tick: got %h exp %h", obs, {3'b010, 12'h000}); end
    bell = 1'b1; step(1); bell = 1'b0; door = 1'b1; step(1); door = 1'b0; step(1);
  endtask

  task automatic test_async_reset;
    for (int i = 0; i < 3; i++) press(1);
    key_start = 1'b1; step(1); key_start = 1'b0;
    heat = 1'b1; step(2);
    vec++; if (obs !== {3'b001, 12'h030}) begin errs++; $display("FAIL run_0_30: got %h exp %h", obs, {3'b001, 12'h030}); end
    #2 nrst = 1'b0;
    #1;
    vec++; if (obs !== 15'h0) begin errs++; $display("FAIL async_reset: got %h exp %h", obs, 15'h0); end
    heat = 1'b0;
    @(negedge clk) nrst = 1'b1;
    step(1);
    vec++; if (obs !== 15'h0) begin errs++; $display("FAIL post_reset: got %h exp %h", obs, 15'h0); end
    press(0);
    vec++; if (obs !== {3'b000, 12'h100}) begin errs++; $display("FAIL setup_after_reset: got %h exp %h", obs, {3'b000, 12'h100}); end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_countdown();
    test_finish();
    test_door_before_bell();
    test_start_ignored();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
